// File: rtl/pwm_sample_decoder.sv
// pwm_sample_decoder: recovers PWM high time and frame period from an asynchronous single-bit stream
module pwm_sample_decoder #(
    parameter int WIDTH      = 8,
    parameter int MAX_PERIOD = 1023,
    parameter int CNT_W      = $clog2(MAX_PERIOD + 1)
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             en,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] sample,
    output logic [CNT_W-1:0] period,
    output logic             sample_valid,
    output logic             lost,
    output logic             locked
);
    typedef enum logic [1:0] {IDLE, SYNC, HIGH, LOW} state_t;
    localparam logic [CNT_W-1:0] MAXC   = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(MAX_PERIOD - 1);
    localparam logic [CNT_W-1:0] SMAX   = CNT_W'((1 << WIDTH) - 1);
    state_t state, nstate;
    logic s1, s2, p, rise, fall, to, done, sv_d, lost_d;
    logic [CNT_W-1:0] cnt, cnt_d, hcnt, hcnt_d;
    assign rise = s2 & ~p;
    assign fall = ~s2 & p;
    // the count about to reach MAX_PERIOD is the timeout; it outranks a coincident rise
    assign to   = (state != IDLE) && (cnt == TO_CNT);
    assign done = (state == LOW) && rise && !to;
    // two-flop synchroniser plus a delayed copy for edge detection; runs regardless of en
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) {s1, s2, p} <= '0;
        else {s1, s2, p} <= {pwm_in, s1, s2};
    end
    // state and frame counters
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            cnt   <= '0;
            hcnt  <= '0;
        end else begin
            state <= nstate;
            cnt   <= cnt_d;
            hcnt  <= hcnt_d;
        end
    end
    // next state and counter values; a terminating rise immediately opens the next frame
    always_comb begin
        nstate = state;
        cnt_d  = cnt;
        hcnt_d = hcnt;
        if (!en) begin
            nstate = IDLE;
            cnt_d  = '0;
            hcnt_d = '0;
        end else begin
            case (state)
                IDLE: nstate = SYNC;
                SYNC: begin
                    if (to) cnt_d = '0;
                    else if (rise) begin
                        nstate = HIGH;
                        cnt_d  = CNT_W'(1);
                        hcnt_d = CNT_W'(1);
                    end else cnt_d = cnt + CNT_W'(1);
                end
                HIGH: begin
                    if (to) begin
                        nstate = SYNC;
                        cnt_d  = '0;
                        hcnt_d = '0;
                    end else if (fall) begin
                        nstate = LOW;
                        cnt_d  = cnt + CNT_W'(1);
                    end else begin
                        cnt_d  = cnt + CNT_W'(1);
                        hcnt_d = (hcnt == MAXC) ? hcnt : hcnt + CNT_W'(1);
                    end
                end
                LOW: begin
                    if (to) begin
                        nstate = SYNC;
                        cnt_d  = '0;
                        hcnt_d = '0;
                    end else if (rise) begin
                        nstate = HIGH;
                        cnt_d  = CNT_W'(1);
                        hcnt_d = CNT_W'(1);
                    end else cnt_d = cnt + CNT_W'(1);
                end
                default: nstate = IDLE;
            endcase
        end
    end
    // strobes and lock indication derived from the current state
    always_comb begin
        locked = (state == HIGH) || (state == LOW);
        sv_d   = en && done;
        lost_d = en && to;
    end
    // registered results; sample and period only move on a completed frame
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sample       <= '0;
            period       <= '0;
            sample_valid <= 1'b0;
            lost         <= 1'b0;
        end else begin
            sample_valid <= sv_d;
            lost         <= lost_d;
            if (sv_d) begin
                sample <= (hcnt > SMAX) ? '1 : WIDTH'(hcnt);
                period <= cnt;
            end
        end
    end
endmodule

// File: tb/tb_pwm_sample_decoder.sv
// tb_pwm_sample_decoder: directed PWM frames with a scoreboard of expected strobes
module tb_pwm_sample_decoder;
    logic clk = 1'b0;
    logic nrst, en, pwm_in;
    logic [7:0] sample;
    logic [9:0] period;
    logic sample_valid, lost, locked;

    pwm_sample_decoder dut (
        .clk(clk), .nrst(nrst), .en(en), .pwm_in(pwm_in),
        .sample(sample), .period(period), .sample_valid(sample_valid),
        .lost(lost), .locked(locked)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_lost;
        int cyc;
        int s;
        int p;
    } ev_t;

    ev_t sbq[$];
    ev_t e;
    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    int prev_h, prev_p, last_s, last_p;
    bit have_prev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    task automatic push_ev(input bit is_lost, input int at, input int s, input int p);
        ev_t x;
        x.is_lost = is_lost;
        x.cyc = at;
        x.s = s;
        x.p = p;
        sbq.push_back(x);
    endtask

    // a rise driven now terminates the previous frame; its strobe shows 3 clk later
    task automatic push_valid();
        last_s = sat(prev_h);
        last_p = prev_p;
        push_ev(1'b0, cyc + 3, last_s, last_p);
    endtask

    task automatic frame(input int h, input int p);
        if (have_prev) push_valid();
        pwm_in = 1'b1;
        tick(h);
        chk("locked_in_frame", int'(locked), 1);
        pwm_in = 1'b0;
        tick(p - h);
        prev_h = h;
        prev_p = p;
        have_prev = 1'b1;
    endtask

    // monitor: every strobe must match the head of the scoreboard
    always @(negedge clk) begin
        if (nrst && (sample_valid || lost)) begin
            chk("strobe_exclusive", int'(sample_valid & lost), 0);
            if (sbq.size() == 0) chk("unexpected_strobe", 1, 0);
            else begin
                e = sbq.pop_front();
                chk(e.is_lost ? "lost_cycle" : "valid_cycle", cyc, e.cyc);
                chk("lost_flag", int'(lost), int'(e.is_lost));
                chk("sample", int'(sample), e.s);
                chk("period", int'(period), e.p);
            end
        end
    end

    initial begin
        nrst = 1'b0;
        en = 1'b0;
        pwm_in = 1'b0;
        have_prev = 1'b0;
        last_s = 0;
        last_p = 0;
        tick(1);
        pwm_in = 1'b1;
        tick(2);
        chk("rst_sample", int'(sample), 0);
        chk("rst_period", int'(period), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_lost", int'(lost), 0);
        chk("rst_locked", int'(locked), 0);
        nrst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pwm_in = ~pwm_in;
            tick(3);
            chk("idle_locked", int'(locked), 0);
            chk("idle_valid", int'(sample_valid), 0);
        end
        pwm_in = 1'b0;
        tick(3);

        en = 1'b1;
        tick(3);
        frame(64, 256);
        frame(64, 256);
        frame(10, 256);
        frame(200, 256);
        frame(255, 256);
        frame(400, 600);

        push_valid();
        pwm_in = 1'b1;
        push_ev(1'b1, cyc + 1025, last_s, last_p);
        tick(1100);
        chk("stuck_high_unlocked", int'(locked), 0);
        en = 1'b0;
        pwm_in = 1'b0;
        have_prev = 1'b0;
        tick(3);

        en = 1'b1;
        push_ev(1'b1, cyc + 1024, last_s, last_p);
        push_ev(1'b1, cyc + 2047, last_s, last_p);
        tick(2100);
        chk("stuck_low_unlocked", int'(locked), 0);
        en = 1'b0;
        tick(3);

        en = 1'b1;
        tick(3);
        pwm_in = 1'b1;
        tick(20);
        chk("abort_locked_before", int'(locked), 1);
        en = 1'b0;
        tick(1);
        chk("abort_locked_after", int'(locked), 0);
        tick(5);
        pwm_in = 1'b0;
        tick(5);
        en = 1'b1;
        tick(3);
        frame(30, 100);
        frame(50, 100);
        chk("resume_sample", int'(sample), 30);

        push_valid();
        pwm_in = 1'b1;
        tick(20);
        pwm_in = 1'b0;
        tick(30);
        chk("mid_low_locked", int'(locked), 1);
        chk("mid_low_sample", int'(sample), 50);
        nrst = 1'b0;
        #1;
        chk("arst_sample", int'(sample), 0);
        chk("arst_period", int'(period), 0);
        chk("arst_locked", int'(locked), 0);
        chk("arst_valid", int'(sample_valid), 0);
        tick(3);
        nrst = 1'b1;
        tick(20);
        chk("pending_events", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pwm_sample_decoder.md
Name: pwm_sample_decoder

Overview:
- Receiver for the single-bit PWM audio stream (`sigout`) that the synth core drives out on its GPIO pin.
- Recovers each frame's high time as a sample value and reports the measured frame period.
- Used on the loopback/characterisation path and by the bench to check the audio output numerically.
- Input is asynchronous to `clk`, so it is synchronised internally.

Parameters:
- WIDTH, 8, bit width of the recovered sample; high-time counts above 2^WIDTH-1 saturate.
- MAX_PERIOD, 1023, longest legal frame in clk cycles; reaching it without a frame completing is a timeout.
- CNT_W, $clog2(MAX_PERIOD+1) (=10), width of the period and internal counters.

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- en  input  1  decoder enable; low forces IDLE
- pwm_in  input  1  raw PWM stream, asynchronous
- sample  output  WIDTH  last recovered sample (high-cycle count, saturated)
- period  output  CNT_W  last measured frame length in cycles
- sample_valid  output  1  one-cycle strobe; sample and period updated this cycle
- lost  output  1  one-cycle strobe on timeout
- locked  output  1  high while a frame is being measured (state HIGH or LOW)

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous active-low on `nrst`. All flops clear on nrst=0.
- Reset values: sample=0, period=0, sample_valid=0, lost=0, locked=0, state=IDLE, all sync flops 0.
- Synchroniser: s1<=pwm_in; s2<=s1; p<=s2.
  - rise = s2 & ~p; fall = ~s2 & p.
  - A pwm_in edge appears on rise/fall 2 clk later.
- Counter: cnt of CNT_W bits.
  - hcnt is the high count, saturating at MAX_PERIOD.
  - Both are used only in HIGH and LOW.
- State IDLE:
  - locked=0, counters held at 0.
  - en=1 -> SYNC.
- State SYNC: waits for rise; cnt counts cycles waiting.
  - rise -> HIGH with cnt=1, hcnt=1. The rise cycle counts as high cycle 1.
  - cnt reaching MAX_PERIOD -> pulse lost, cnt=0, stay in SYNC.
- State HIGH:
  - Each cycle with s2=1: cnt+1, hcnt+1.
  - fall -> LOW, cnt+1. The fall cycle is the first low cycle.
- State LOW:
  - Each cycle: cnt+1.
  - rise -> frame complete.
    - Registered next edge: sample=min(hcnt, 2^WIDTH-1), period=cnt, sample_valid=1 for exactly 1 cycle.
    - This rise starts the next frame in the same cycle: HIGH, cnt=1, hcnt=1. There are no dead cycles between back-to-back frames.
- Output latency: sample_valid rises 1 clk after the decoder rise. That is 3 clk after the terminating pwm_in rising edge.
- Timeout in HIGH or LOW (stuck-high or stuck-low input):
  - If cnt reaches MAX_PERIOD before a terminating rise: pulse lost for 1 cycle, go to SYNC, cnt=0.
  - No sample_valid; sample and period hold their previous values.
- locked=1 exactly in HIGH and LOW.
- en=0 in any state: next cycle state=IDLE and counters clear.
  - Any in-progress frame is discarded; no sample_valid, no lost.
  - sample and period hold.
  - Sync flops keep running, so re-enable sees a correct p with no false rise.
- sample_valid and lost are never asserted in the same cycle.
  - Timeout takes priority if MAX_PERIOD is reached in the same cycle as a rise.
- Async reset mid-frame: immediate clear to the reset values above. The partial frame is dropped.
- Arithmetic: all counters are unsigned; no wrap is possible because counting stops at MAX_PERIOD.

Test Plan:
- Reset/idle: nrst low, then high with en=0 and the input toggling -> all outputs 0, locked=0 throughout.
- Basic decode: en=1, two frames of 256 clk, 64 high -> first frame only locks. On the second frame's terminating rise: sample=64, period=256, one-cycle sample_valid 3 clk after the pwm_in edge.
- Back-to-back frames: periods 256 with highs 10, 200, 255 -> three consecutive strobes with sample 10, 200, 255. Strobes are spaced exactly 256 clk; locked stays 1.
- Saturation: period 600, high 400 -> sample=255, period=600.
- Timeouts:
  - Input stuck high after a rise -> lost pulse when cnt hits 1023, state returns to SYNC, sample holds its prior value.
  - Input stuck low from enable -> lost every 1023 clk.
- Abort and reset: en dropped mid-HIGH -> no strobe, locked=0 next cycle; re-enable resumes correct decode. nrst asserted mid-LOW -> outputs clear immediately.
